control_sequencer: RTL and testbench

- Hardwired micro-sequencer driving the 32-bit DataPath: instruction fetch, decode and per-class execute steps (T0..T7).
- Emits one-hot register-enable / bus-out strobes, ALU opcode, memory read, and the Gra/Grb/Grc/Rin/Rout/BAout select controls consumed by the register-select logic.
- Sits beside the DataPath at top level; the only state it observes is IR and the branch condition flag.

---
 rtl/ctrl_pkg.sv | 80 ++++++++
 rtl/seq_mem_wait.sv | 28 ++
 rtl/control_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_control_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared opcodes, states, step numbers and strobe bundle for the hardwired
// control sequencer.
package ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_ADD = OP_ADD;

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;
  localparam logic [2:0] T5 = 3'd5;
  localparam logic [2:0] T6 = 3'd6;
  localparam logic [2:0] T7 = 3'd7;

  typedef enum logic [2:0] {
    S_FETCH, S_EXEC, S_MWAIT, S_HALTED, S_STOPPED
  } state_e;

  typedef enum logic [3:0] {
    C_LD, C_LDI, C_ST, C_ALU, C_IMM, C_MULDIV, C_UNARY, C_BR,
    C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
  } iclass_e;

  typedef struct packed {
    logic pc_out, inc_pc, pc_in, mar_in, mdr_in, mem_read, mem_write, ir_in;
    logic zhi_out, zlo_out, rz_in, ry_in, hi_in, lo_in, hi_out, lo_out;
    logic mdr_out, c_out, inport_out, outport_in;
    logic gra, grb, grc, r_in, r_out, ba_out, con_in;
    logic [4:0] alu_op;
  } strobe_t;

  // Unlisted opcodes (11100..11111) fall through to nop.
  function automatic iclass_e op_class(input logic [4:0] op);
    iclass_e c;
    c = C_NOP;
    case (op)
      OP_LD:           c = C_LD;
      OP_LDI:          c = C_LDI;
      OP_ST:           c = C_ST;
      OP_MUL, OP_DIV:  c = C_MULDIV;
      OP_NEG, OP_NOT:  c = C_UNARY;
      OP_BR:           c = C_BR;
      OP_JR:           c = C_JR;
      OP_JAL:          c = C_JAL;
      OP_IN:           c = C_IN;
      OP_OUT:          c = C_OUT;
      OP_MFHI:         c = C_MFHI;
      OP_MFLO:         c = C_MFLO;
      OP_HALT:         c = C_HALT;
      default: begin
        if (op >= OP_ADD && op <= OP_SHL)       c = C_ALU;
        else if (op >= OP_ADDI && op <= OP_ORI) c = C_IMM;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/seq_mem_wait.sv
// Loadable down-counter timing the memory wait cycles; done_o marks the
// last wait cycle.
module seq_mem_wait #(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic clk_i,
  input  logic clear_i,
  input  logic load_i,
  input  logic dec_i,
  output logic done_o
);

  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                 cnt_d = 2'(MEM_WAIT - 1);
    else if (dec_i && cnt_q != '0) cnt_d = cnt_q - 2'd1;
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/control_sequencer.sv
// Hardwired micro-sequencer: fetch, decode and per-class execute steps,
// with strobes decoded combinationally from state, step and opcode.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 1,
  parameter int unsigned OPW      = 5
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        stop,
  output logic        run,
  output logic [2:0]  step,
  output logic        PCout, IncPC, PCin, MARin, MDRin, Mem_read, Mem_write, IRin,
  output logic        Zhi_out, Zlo_out, RZin, RYin, HIin, LOin, HIout, LOout, MDRout, Cout,
  output logic        Inport_out, Outport_in,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout, CONin,
  output logic [4:0]  alu_op
);

  state_e     state_q, state_d;
  logic [2:0] step_q, step_d;
  logic       wait_load, wait_dec, wait_done, last, mem;
  logic [OPW-1:0] opc;
  iclass_e    cls;
  strobe_t    s, so;
  logic       unused_ir;

  assign opc       = ir[31 -: OPW];
  assign cls       = op_class(opc);
  assign unused_ir = ^ir[31-OPW:0];

  seq_mem_wait #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .clk_i   (clock),
    .clear_i (clear),
    .load_i  (wait_load),
    .dec_i   (wait_dec),
    .done_o  (wait_done)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_FETCH;
      step_q  <= T0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d = step_q;
    s = '0;
    wait_load = 1'b0;
    wait_dec = 1'b0;
    last = 1'b0;
    mem = 1'b0;
    case (state_q)
      S_FETCH: begin
        case (step_q)
          T0: begin
            if (stop) state_d = S_STOPPED;
            else begin
              s.pc_out = 1'b1; s.mar_in = 1'b1; s.inc_pc = 1'b1; s.rz_in = 1'b1;
              step_d = T1;
            end
          end
          T1: begin
            s.zlo_out = 1'b1; s.pc_in = 1'b1; s.mem_read = 1'b1; s.mdr_in = 1'b1;
            state_d = S_MWAIT;
            wait_load = 1'b1;
          end
          default: begin
            s.mdr_out = 1'b1; s.ir_in = 1'b1;
            state_d = S_EXEC;
            step_d = T3;
          end
        endcase
      end
      S_EXEC: begin
        case (cls)
          C_LD, C_LDI, C_ST: begin
            case (step_q)
              T3: begin s.grb = 1'b1; s.ba_out = 1'b1; s.ry_in = 1'b1; end
              T4: begin s.c_out = 1'b1; s.alu_op = ALU_ADD; s.rz_in = 1'b1; end
              T5: begin
                s.zlo_out = 1'b1;
                if (cls == C_LDI) begin s.gra = 1'b1; s.r_in = 1'b1; last = 1'b1; end
                else s.mar_in = 1'b1;
              end
              T6: begin
                s.mdr_in = 1'b1;
                if (cls == C_LD) begin s.mem_read = 1'b1; mem = 1'b1; end
                else begin s.gra = 1'b1; s.r_out = 1'b1; end
              end
              default: begin
                if (cls == C_LD) begin s.mdr_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; last = 1'b1; end
                else begin s.mem_write = 1'b1; mem = 1'b1; end
              end
            endcase
          end
          C_ALU, C_IMM: begin
            case (step_q)
              T3: begin s.grb = 1'b1; s.r_out = 1'b1; s.ry_in = 1'b1; end
              T4: begin
                if (cls == C_ALU) begin s.grc = 1'b1; s.r_out = 1'b1; end
                else s.c_out = 1'b1;
                s.alu_op = opc; s.rz_in = 1'b1;
              end
              default: begin s.zlo_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; last = 1'b1; end
            endcase
          end
          C_MULDIV: begin
            case (step_q)
              T3: begin s.gra = 1'b1; s.r_out = 1'b1; s.ry_in = 1'b1; end
              T4: begin s.grb = 1'b1; s.r_out = 1'b1; s.rz_in = 1'b1; end
              T5: begin s.zlo_out = 1'b1; s.lo_in = 1'b1; end
              default: begin s.zhi_out = 1'b1; s.hi_in = 1'b1; last = 1'b1; end
            endcase
          end
          C_UNARY: begin
            if (step_q == T3) begin s.grb = 1'b1; s.r_out = 1'b1; s.alu_op = opc; s.rz_in = 1'b1; end
            else begin s.zlo_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; last = 1'b1; end
          end
          C_BR: begin
            // Not-taken branches end at T5 since con_ff is already valid there.
            case (step_q)
              T3: begin s.gra = 1'b1; s.r_out = 1'b1; s.con_in = 1'b1; end
              T4: begin s.pc_out = 1'b1; s.ry_in = 1'b1; end
              T5: begin s.c_out = 1'b1; s.alu_op = ALU_ADD; s.rz_in = 1'b1; last = !con_ff; end
              default: begin s.zlo_out = 1'b1; s.pc_in = 1'b1; last = 1'b1; end
            endcase
          end
          C_JR: begin s.gra = 1'b1; s.r_out = 1'b1; s.pc_in = 1'b1; last = 1'b1; end
          C_JAL: begin
            if (step_q == T3) begin s.pc_out = 1'b1; s.grb = 1'b1; s.r_in = 1'b1; end
            else begin s.gra = 1'b1; s.r_out = 1'b1; s.pc_in = 1'b1; last = 1'b1; end
          end
          C_IN:   begin s.inport_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; last = 1'b1; end
          C_OUT:  begin s.gra = 1'b1; s.r_out = 1'b1; s.outport_in = 1'b1; last = 1'b1; end
          C_MFHI: begin s.hi_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; last = 1'b1; end
          C_MFLO: begin s.lo_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; last = 1'b1; end
          C_HALT: ;
          default: last = 1'b1;
        endcase
        if (cls == C_HALT) begin
          state_d = S_HALTED;
          step_d = T0;
        end else if (mem) begin
          state_d = S_MWAIT;
          wait_load = 1'b1;
        end else if (last) begin
          state_d = S_FETCH;
          step_d = T0;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      S_MWAIT: begin
        // step_q still holds the step that started the wait: T1 fetch, T6 load, T7 store.
        wait_dec = 1'b1;
        if (step_q == T7) s.mem_write = 1'b1;
        else begin s.mem_read = 1'b1; s.mdr_in = 1'b1; end
        if (wait_done) begin
          if (step_q == T1) begin state_d = S_FETCH; step_d = T2; end
          else if (step_q == T7) begin state_d = S_FETCH; step_d = T0; end
          else begin state_d = S_EXEC; step_d = step_q + 3'd1; end
        end
      end
      S_HALTED: ;
      default: begin
        if (!stop) begin
          state_d = S_FETCH;
          step_d = T0;
        end
      end
    endcase
  end

  assign so   = clear ? '0 : s;
  assign run  = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_MWAIT);
  assign step = step_q;

  assign PCout = so.pc_out;       assign IncPC = so.inc_pc;     assign PCin = so.pc_in;
  assign MARin = so.mar_in;       assign MDRin = so.mdr_in;     assign Mem_read = so.mem_read;
  assign Mem_write = so.mem_write; assign IRin = so.ir_in;      assign Zhi_out = so.zhi_out;
  assign Zlo_out = so.zlo_out;    assign RZin = so.rz_in;       assign RYin = so.ry_in;
  assign HIin = so.hi_in;         assign LOin = so.lo_in;       assign HIout = so.hi_out;
  assign LOout = so.lo_out;       assign MDRout = so.mdr_out;   assign Cout = so.c_out;
  assign Inport_out = so.inport_out; assign Outport_in = so.outport_in;
  assign Gra = so.gra;            assign Grb = so.grb;          assign Grc = so.grc;
  assign Rin = so.r_in;           assign Rout = so.r_out;       assign BAout = so.ba_out;
  assign CONin = so.con_in;       assign alu_op = so.alu_op;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-instruction expected cycle lists built from
// the instruction-class tables, compared against the DUT every cycle.
module tb_control_sequencer;

  localparam int unsigned MW = 2;

  logic clock = 1'b0;
  logic clear, con_ff, stop;
  logic [31:0] ir;
  logic run;
  logic [2:0] step;
  logic PCout, IncPC, PCin, MARin, MDRin, Mem_read, Mem_write, IRin;
  logic Zhi_out, Zlo_out, RZin, RYin, HIin, LOin, HIout, LOout, MDRout, Cout;
  logic Inport_out, Outport_in, Gra, Grb, Grc, Rin, Rout, BAout, CONin;
  logic [4:0] alu_op;

  always #5 clock = ~clock;

  control_sequencer #(.MEM_WAIT(MW), .OPW(5)) dut (
    .clock(clock), .clear(clear), .ir(ir), .con_ff(con_ff), .stop(stop),
    .run(run), .step(step),
    .PCout(PCout), .IncPC(IncPC), .PCin(PCin), .MARin(MARin), .MDRin(MDRin),
    .Mem_read(Mem_read), .Mem_write(Mem_write), .IRin(IRin),
    .Zhi_out(Zhi_out), .Zlo_out(Zlo_out), .RZin(RZin), .RYin(RYin), .HIin(HIin),
    .LOin(LOin), .HIout(HIout), .LOout(LOout), .MDRout(MDRout), .Cout(Cout),
    .Inport_out(Inport_out), .Outport_in(Outport_in),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .CONin(CONin),
    .alu_op(alu_op)
  );

  logic [26:0] act;
  assign act = {CONin, BAout, Rout, Rin, Grc, Grb, Gra, Outport_in, Inport_out, Cout,
                MDRout, LOout, HIout, LOin, HIin, RYin, RZin, Zlo_out, Zhi_out, IRin,
                Mem_write, Mem_read, MDRin, MARin, PCin, IncPC, PCout};

  localparam logic [26:0] PCOUT  = 27'd1 << 0,  INCPC  = 27'd1 << 1,  PCIN   = 27'd1 << 2;
  localparam logic [26:0] MARIN  = 27'd1 << 3,  MDRIN  = 27'd1 << 4,  MRD    = 27'd1 << 5;
  localparam logic [26:0] MWR    = 27'd1 << 6,  IRIN   = 27'd1 << 7,  ZHI    = 27'd1 << 8;
  localparam logic [26:0] ZLO    = 27'd1 << 9,  RZIN   = 27'd1 << 10, RYIN   = 27'd1 << 11;
  localparam logic [26:0] HIIN   = 27'd1 << 12, LOIN   = 27'd1 << 13, HIOUT  = 27'd1 << 14;
  localparam logic [26:0] LOOUT  = 27'd1 << 15, MDROUT = 27'd1 << 16, COUT   = 27'd1 << 17;
  localparam logic [26:0] INPORT = 27'd1 << 18, OUTPRT = 27'd1 << 19, GRA    = 27'd1 << 20;
  localparam logic [26:0] GRB    = 27'd1 << 21, GRC    = 27'd1 << 22, RIN    = 27'd1 << 23;
  localparam logic [26:0] ROUT   = 27'd1 << 24, BAOUT  = 27'd1 << 25, CONIN  = 27'd1 << 26;
  localparam logic [26:0] BUSOUT = PCOUT | ZHI | ZLO | HIOUT | LOOUT | MDROUT | COUT | INPORT | ROUT | BAOUT;

  typedef struct packed {
    logic        run;
    logic [2:0]  stp;
    logic [26:0] s;
    logic [4:0]  alu;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail = 0;
  int mr6 = 0;
  int ops [20] = '{1, 2, 4, 11, 12, 13, 14, 15, 16, 17, 18, 20, 21, 22, 23, 24, 25, 26, 28, 31};

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, a, e, $time);
    end
  endtask

  task automatic add(input logic [2:0] t, input logic [26:0] s, input logic [4:0] a);
    q.push_back('{1'b1, t, s, a});
  endtask

  task automatic add_idle(input logic r, input logic [2:0] t);
    q.push_back('{r, t, 27'd0, 5'd0});
  endtask

  // Whole-instruction expectation: fetch, then the class's step list from T3.
  task automatic push_instr(input int op, input logic con);
    logic [4:0] o;
    o = 5'(op);
    add(0, PCOUT | MARIN | INCPC | RZIN, 0);
    add(1, ZLO | PCIN | MRD | MDRIN, 0);
    repeat (MW) add(1, MRD | MDRIN, 0);
    add(2, MDROUT | IRIN, 0);
    if (op <= 2) begin
      add(3, GRB | BAOUT | RYIN, 0);
      add(4, COUT | RZIN, 5'd3);
      if (op == 1) add(5, ZLO | GRA | RIN, 0);
      else begin
        add(5, ZLO | MARIN, 0);
        if (op == 0) begin
          repeat (MW + 1) add(6, MRD | MDRIN, 0);
          add(7, MDROUT | GRA | RIN, 0);
        end else begin
          add(6, GRA | ROUT | MDRIN, 0);
          repeat (MW + 1) add(7, MWR, 0);
        end
      end
    end else if (op <= 14) begin
      add(3, GRB | ROUT | RYIN, 0);
      add(4, ((op <= 11) ? (GRC | ROUT) : COUT) | RZIN, o);
      add(5, ZLO | GRA | RIN, 0);
    end else if (op <= 16) begin
      add(3, GRA | ROUT | RYIN, 0);
      add(4, GRB | ROUT | RZIN, 0);
      add(5, ZLO | LOIN, 0);
      add(6, ZHI | HIIN, 0);
    end else if (op <= 18) begin
      add(3, GRB | ROUT | RZIN, o);
      add(4, ZLO | GRA | RIN, 0);
    end else if (op == 19) begin
      add(3, GRA | ROUT | CONIN, 0);
      add(4, PCOUT | RYIN, 0);
      add(5, COUT | RZIN, 5'd3);
      if (con) add(6, ZLO | PCIN, 0);
    end else if (op == 20) add(3, GRA | ROUT | PCIN, 0);
    else if (op == 21) begin
      add(3, PCOUT | GRB | RIN, 0);
      add(4, GRA | ROUT | PCIN, 0);
    end
    else if (op == 22) add(3, INPORT | GRA | RIN, 0);
    else if (op == 23) add(3, GRA | ROUT | OUTPRT, 0);
    else if (op == 24) add(3, HIOUT | GRA | RIN, 0);
    else if (op == 25) add(3, LOOUT | GRA | RIN, 0);
    else add(3, 0, 0);
  endtask

  task automatic drain(input string nm, output int cyc);
    cyc = 0;
    while (q.size() != 0 && cyc < 200) begin
      @(posedge clock);
      cyc++;
    end
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d pending entries, expected 0", nm, q.size());
      q.delete();
    end
    #1;
  endtask

  initial begin : cmp
    exp_t e;
    forever begin
      @(negedge clock);
      if (Mem_read && step == 3'd6) mr6++;
      n_checks++;
      assert ($countones(act & BUSOUT) <= 1)
      else begin
        n_fail++;
        $display("FAIL busout_onehot: got 0x%0h, expected at most one bus-out bit", act & BUSOUT);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk($sformatf("run@T%0d", e.stp), 32'(run), 32'(e.run));
        chk("step", 32'(step), 32'(e.stp));
        chk($sformatf("strobes@T%0d", e.stp), 32'(act), 32'(e.s));
        chk($sformatf("alu_op@T%0d", e.stp), 32'(alu_op), 32'(e.alu));
      end
    end
  end

  initial begin : stim
    int c, m0;
    logic [4:0] o;
    clear = 1'b1; stop = 1'b0; con_ff = 1'b0; ir = '0;
    @(posedge clock);
    @(negedge clock);
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_run", 32'(run), 32'd1);
    chk("rst_strobes", 32'(act), 32'd0);
    chk("rst_alu", 32'(alu_op), 32'd0);
    @(posedge clock); #1;
    clear = 1'b0;

    ir = 32'h1A000000;
    push_instr(3, 1'b0);
    chk("add_model_len", 32'(q.size()), 32'd8);
    drain("add", c);

    ir = 32'h00000000;
    m0 = mr6;
    push_instr(0, 1'b0);
    chk("ld_model_len", 32'(q.size()), 32'd12);
    drain("ld", c);
    chk("ld_cycles", 32'(c), 32'd12);
    chk("ld_memread_T6", 32'(mr6 - m0), 32'd3);

    ir = {5'b10011, 27'd0};
    con_ff = 1'b1;
    push_instr(19, 1'b1);
    drain("br_taken", c);
    chk("br_taken_cycles", 32'(c), 32'd9);
    con_ff = 1'b0;
    push_instr(19, 1'b0);
    drain("br_not_taken", c);
    chk("br_not_taken_cycles", 32'(c), 32'd8);

    foreach (ops[i]) begin
      o = 5'(ops[i]);
      ir = {o, 27'h155AA33};
      push_instr(ops[i], 1'b0);
      drain($sformatf("op%0d", ops[i]), c);
    end

    // clear while a load sits at T5, held for two edges
    ir = 32'h00000000;
    push_instr(0, 1'b0);
    repeat (5) void'(q.pop_back());
    drain("ld_pre_clear", c);
    clear = 1'b1;
    add_idle(1'b1, 3'd5);
    add_idle(1'b1, 3'd0);
    drain("clear_mid_ld", c);
    clear = 1'b0;
    ir = {5'b11010, 27'd0};
    push_instr(26, 1'b0);
    drain("after_clear", c);

    ir = 32'h1A000000;
    stop = 1'b1;
    add_idle(1'b1, 3'd0);
    add_idle(1'b0, 3'd0);
    add_idle(1'b0, 3'd0);
    drain("stopped", c);
    stop = 1'b0;
    add_idle(1'b0, 3'd0);
    push_instr(3, 1'b0);
    drain("after_stop", c);

    ir = {5'b11011, 27'd0};
    push_instr(27, 1'b0);
    repeat (20) add_idle(1'b0, 3'd0);
    drain("halt", c);
    clear = 1'b1;
    add_idle(1'b0, 3'd0);
    drain("halt_clear", c);
    clear = 1'b0;
    ir = {5'b11010, 27'd0};
    push_instr(26, 1'b0);
    drain("after_halt", c);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
